// File: rtl/gate_response_checker_pkg.sv
// Shared encodings for the gate response checker family: FSM states and
// mismatch-mask bit positions.
package gate_response_checker_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int MM_AND = 2;
    localparam int MM_OR  = 1;
    localparam int MM_NOT = 0;

endpackage

// File: rtl/gate_response_checker_if.sv
// Stimulus/response bundle between the gate stimulus side and the checker.
interface gate_response_checker_if #(
    parameter int CNT_W = 8
) ();
    logic             iStart;
    logic             iValid;
    logic             iA;
    logic             iB;
    logic             iAnd;
    logic             iOr;
    logic             iNot;
    logic             oBusy;
    logic             oDone;
    logic             oPass;
    logic [CNT_W-1:0] oVecCnt;
    logic [CNT_W-1:0] oErrCnt;
    logic [1:0]       oFirstAB;
    logic [2:0]       oMismatch;
    logic             oOverrun;
    logic [3:0]       oCovered;

    modport master (
        output iStart, iValid, iA, iB, iAnd, iOr, iNot,
        input  oBusy, oDone, oPass, oVecCnt, oErrCnt, oFirstAB, oMismatch,
               oOverrun, oCovered
    );

    modport slave (
        input  iStart, iValid, iA, iB, iAnd, iOr, iNot,
        output oBusy, oDone, oPass, oVecCnt, oErrCnt, oFirstAB, oMismatch,
               oOverrun, oCovered
    );
endinterface

// File: rtl/gate_response_checker_ref_model.sv
// gate_ref_model: combinational reference for the basic gates,
// {A,B} -> expected {and,or,not(A)} placed at the shared mismatch positions.
module gate_ref_model
    import gate_response_checker_pkg::*;
(
    input  logic [1:0] i_ab,
    output logic [2:0] o_exp
);
    // Expected gate outputs from the latched stimulus.
    always_comb begin
        o_exp         = 3'b000;
        o_exp[MM_AND] = i_ab[1] & i_ab[0];
        o_exp[MM_OR]  = i_ab[1] | i_ab[0];
        o_exp[MM_NOT] = ~i_ab[1];
    end
endmodule

// File: rtl/gate_response_checker.sv
// Gate response checker: latches each applied vector, waits a settle window,
// compares the gate outputs to gate_ref_model. Optional: GATE_CHK_COVERAGE_EN.
module gate_response_checker
    import gate_response_checker_pkg::*;
#(
    parameter int NUM_VECTORS   = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic                   iClk,
    input  logic                   iRst,
    gate_response_checker_if.slave bus
);
    localparam int SETTLE_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_vec, w_vec_nxt;
    logic [SETTLE_W-1:0] r_settle, w_settle_nxt;
    logic [CNT_W-1:0]    r_vec_cnt, w_vec_cnt_nxt;
    logic [CNT_W-1:0]    r_err_cnt, w_err_cnt_nxt;
    logic [1:0]          r_first_ab, w_first_ab_nxt;
    logic [2:0]          r_mismatch, w_mismatch_nxt;
    logic                r_overrun, w_overrun_nxt;
    logic                r_busy, r_done, r_pass;
    logic                w_clear;
    logic [2:0]          w_exp, w_obs, w_diff;

    gate_ref_model u_ref (
        .i_ab  (r_vec),
        .o_exp (w_exp)
    );

    // Observed gate outputs arranged in the same bit order as the reference.
    always_comb begin
        w_obs         = 3'b000;
        w_obs[MM_AND] = bus.iAnd;
        w_obs[MM_OR]  = bus.iOr;
        w_obs[MM_NOT] = bus.iNot;
    end

    assign w_diff = w_exp ^ w_obs;

    // Next-state and next-value logic; iStart always wins and clears the run.
    always_comb begin
        w_state_nxt    = r_state;
        w_vec_nxt      = r_vec;
        w_settle_nxt   = r_settle;
        w_vec_cnt_nxt  = r_vec_cnt;
        w_err_cnt_nxt  = r_err_cnt;
        w_first_ab_nxt = r_first_ab;
        w_mismatch_nxt = r_mismatch;
        w_overrun_nxt  = r_overrun;
        w_clear        = 1'b0;
        if (bus.iStart && (r_state != S_IDLE || 1'b1)) begin
            w_clear     = 1'b1;
            w_state_nxt = S_ARM;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    w_state_nxt = r_state;
                end
                S_ARM: begin
                    if (bus.iValid) begin
                        w_vec_nxt    = {bus.iA, bus.iB};
                        w_settle_nxt = '0;
                        w_state_nxt  = S_SETTLE;
                    end else begin
                        w_state_nxt = S_ARM;
                    end
                end
                S_SETTLE: begin
                    if (bus.iValid) begin
                        w_overrun_nxt = 1'b1;
                    end else begin
                        w_overrun_nxt = r_overrun;
                    end
                    if (r_settle == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                        w_state_nxt = S_CHECK;
                    end else begin
                        w_settle_nxt = r_settle + SETTLE_W'(1);
                    end
                end
                S_CHECK: begin
                    if (bus.iValid) begin
                        w_overrun_nxt = 1'b1;
                    end else begin
                        w_overrun_nxt = r_overrun;
                    end
                    w_vec_cnt_nxt = r_vec_cnt + CNT_W'(1);
                    if (w_diff != 3'b000) begin
                        w_mismatch_nxt = w_diff;
                        if (r_err_cnt != {CNT_W{1'b1}}) begin
                            w_err_cnt_nxt = r_err_cnt + CNT_W'(1);
                        end else begin
                            w_err_cnt_nxt = r_err_cnt;
                        end
                        if (r_err_cnt == '0) begin
                            w_first_ab_nxt = r_vec;
                        end else begin
                            w_first_ab_nxt = r_first_ab;
                        end
                    end else begin
                        w_mismatch_nxt = r_mismatch;
                    end
                    if (w_vec_cnt_nxt == CNT_W'(NUM_VECTORS)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_ARM;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
        if (w_clear) begin
            w_vec_cnt_nxt  = '0;
            w_err_cnt_nxt  = '0;
            w_first_ab_nxt = 2'b00;
            w_mismatch_nxt = 3'b000;
            w_overrun_nxt  = 1'b0;
        end else begin
            w_vec_cnt_nxt = w_vec_cnt_nxt;
        end
    end

    // State and result registers; status flags are registered from next state.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state    <= S_IDLE;
            r_vec      <= 2'b00;
            r_settle   <= '0;
            r_vec_cnt  <= '0;
            r_err_cnt  <= '0;
            r_first_ab <= 2'b00;
            r_mismatch <= 3'b000;
            r_overrun  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_vec      <= w_vec_nxt;
            r_settle   <= w_settle_nxt;
            r_vec_cnt  <= w_vec_cnt_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
            r_first_ab <= w_first_ab_nxt;
            r_mismatch <= w_mismatch_nxt;
            r_overrun  <= w_overrun_nxt;
            r_busy     <= (w_state_nxt == S_ARM) || (w_state_nxt == S_SETTLE) ||
                          (w_state_nxt == S_CHECK);
            r_done     <= (w_state_nxt == S_DONE);
            r_pass     <= (w_state_nxt == S_DONE) && (w_err_cnt_nxt == '0);
        end
    end

`ifdef GATE_CHK_COVERAGE_EN
    logic [3:0] r_covered;

    // Coverage bit per checked {A,B}, independent of pass/fail.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_covered <= 4'b0000;
        end else if (w_clear) begin
            r_covered <= 4'b0000;
        end else if (r_state == S_CHECK) begin
            r_covered[r_vec] <= 1'b1;
        end else begin
            r_covered <= r_covered;
        end
    end

    assign bus.oCovered = r_covered;
`else
    assign bus.oCovered = 4'b0000;
`endif

    assign bus.oBusy     = r_busy;
    assign bus.oDone     = r_done;
    assign bus.oPass     = r_pass;
    assign bus.oVecCnt   = r_vec_cnt;
    assign bus.oErrCnt   = r_err_cnt;
    assign bus.oFirstAB  = r_first_ab;
    assign bus.oMismatch = r_mismatch;
    assign bus.oOverrun  = r_overrun;
endmodule

// File: tb/tb_gate_response_checker.sv
// Directed self-checking bench for gate_response_checker (main 4-vector
// instance plus a 255-vector instance for error-count saturation).
module tb_gate_response_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic or_stuck0 = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] exp_cov_full;

    gate_response_checker_if #(.CNT_W(8)) bus ();
    gate_response_checker_if #(.CNT_W(8)) bus2 ();

    gate_response_checker #(.NUM_VECTORS(4), .SETTLE_CYCLES(2), .CNT_W(8)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    gate_response_checker #(.NUM_VECTORS(255), .SETTLE_CYCLES(2), .CNT_W(8)) dut_sat (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus2)
    );

    always #5 clk = ~clk;

    // Gate under test: correct, or with OR stuck at 0 on demand.
    assign bus.iAnd  = bus.iA & bus.iB;
    assign bus.iOr   = or_stuck0 ? 1'b0 : (bus.iA | bus.iB);
    assign bus.iNot  = ~bus.iA;
    // Second gate: NOT output inverted, so every vector fails.
    assign bus2.iAnd = bus2.iA & bus2.iB;
    assign bus2.iOr  = bus2.iA | bus2.iB;
    assign bus2.iNot = bus2.iA;

    task automatic pulse_start();
        bus.iStart = 1'b1;
        @(posedge clk); #1;
        bus.iStart = 1'b0;
    endtask

    task automatic apply_vec(input logic [1:0] ab);
        bus.iA = ab[1]; bus.iB = ab[0]; bus.iValid = 1'b1;
        @(posedge clk); #1;
        bus.iValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", bus.oBusy); end
        checks++; if ({bus.oDone, bus.oPass, bus.oOverrun} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b exp 000", {bus.oDone, bus.oPass, bus.oOverrun}); end
        checks++; if ({bus.oVecCnt, bus.oErrCnt} !== 16'h0000) begin errors++; $display("FAIL reset_cnts: got %h exp 0000", {bus.oVecCnt, bus.oErrCnt}); end
        checks++; if ({bus.oFirstAB, bus.oMismatch, bus.oCovered} !== 9'h000) begin errors++; $display("FAIL reset_regs: got %h exp 000", {bus.oFirstAB, bus.oMismatch, bus.oCovered}); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        checks++; if ({bus.oBusy, bus.oDone, bus.oVecCnt} !== 10'h000) begin errors++; $display("FAIL idle_after_reset: got %h exp 000", {bus.oBusy, bus.oDone, bus.oVecCnt}); end
    endtask

    task automatic test_pass_run();
        or_stuck0 = 1'b0;
        pulse_start();
        checks++; if ({bus.oBusy, bus.oDone} !== 2'b10) begin errors++; $display("FAIL pass_armed: got %b exp 10", {bus.oBusy, bus.oDone}); end
        apply_vec(2'b00);
        checks++; if (bus.oVecCnt !== 8'd1) begin errors++; $display("FAIL pass_first_cnt: got %0d exp 1", bus.oVecCnt); end
        apply_vec(2'b10);
        apply_vec(2'b01);
        apply_vec(2'b11);
        checks++; if ({bus.oDone, bus.oPass, bus.oBusy} !== 3'b110) begin errors++; $display("FAIL pass_done: got %b exp 110", {bus.oDone, bus.oPass, bus.oBusy}); end
        checks++; if (bus.oVecCnt !== 8'd4) begin errors++; $display("FAIL pass_veccnt: got %0d exp 4", bus.oVecCnt); end
        checks++; if (bus.oErrCnt !== 8'd0) begin errors++; $display("FAIL pass_errcnt: got %0d exp 0", bus.oErrCnt); end
        checks++; if (bus.oCovered !== exp_cov_full) begin errors++; $display("FAIL pass_covered: got %b exp %b", bus.oCovered, exp_cov_full); end
        // iValid while DONE is ignored without flagging overrun.
        bus.iValid = 1'b1;
        @(posedge clk); #1;
        bus.iValid = 1'b0;
        repeat (4) @(posedge clk); #1;
        checks++; if ({bus.oDone, bus.oOverrun, bus.oVecCnt} !== {1'b1, 1'b0, 8'd4}) begin errors++; $display("FAIL done_valid_ignored: got %h exp 204", {bus.oDone, bus.oOverrun, bus.oVecCnt}); end
    endtask

    task automatic test_stuck_or();
        or_stuck0 = 1'b1;
        pulse_start();
        checks++; if ({bus.oDone, bus.oVecCnt, bus.oCovered} !== 13'h0000) begin errors++; $display("FAIL stuck_cleared: got %h exp 0000", {bus.oDone, bus.oVecCnt, bus.oCovered}); end
        apply_vec(2'b00);
        apply_vec(2'b10);
        apply_vec(2'b01);
        apply_vec(2'b11);
        checks++; if (bus.oErrCnt !== 8'd3) begin errors++; $display("FAIL stuck_errcnt: got %0d exp 3", bus.oErrCnt); end
        checks++; if (bus.oFirstAB !== 2'b10) begin errors++; $display("FAIL stuck_firstab: got %b exp 10", bus.oFirstAB); end
        checks++; if (bus.oMismatch !== 3'b010) begin errors++; $display("FAIL stuck_mismatch: got %b exp 010", bus.oMismatch); end
        checks++; if ({bus.oDone, bus.oPass, bus.oVecCnt} !== {1'b1, 1'b0, 8'd4}) begin errors++; $display("FAIL stuck_done: got %h exp 204", {bus.oDone, bus.oPass, bus.oVecCnt}); end
        or_stuck0 = 1'b0;
    endtask

    task automatic test_overrun();
        pulse_start();
        bus.iA = 1'b0; bus.iB = 1'b0; bus.iValid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.iValid = 1'b0;
        checks++; if (bus.oOverrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b exp 1", bus.oOverrun); end
        repeat (2) @(posedge clk); #1;
        checks++; if (bus.oVecCnt !== 8'd1) begin errors++; $display("FAIL overrun_veccnt: got %0d exp 1", bus.oVecCnt); end
        repeat (4) @(posedge clk); #1;
        checks++; if ({bus.oVecCnt, bus.oBusy, bus.oOverrun} !== {8'd1, 1'b1, 1'b1}) begin errors++; $display("FAIL overrun_no_recount: got %h exp 07", {bus.oVecCnt, bus.oBusy, bus.oOverrun}); end
    endtask

    task automatic test_abort();
        or_stuck0 = 1'b1;
        pulse_start();
        checks++; if (bus.oOverrun !== 1'b0) begin errors++; $display("FAIL abort_overrun_clr: got %b exp 0", bus.oOverrun); end
        apply_vec(2'b10);
        apply_vec(2'b01);
        checks++; if ({bus.oVecCnt, bus.oErrCnt} !== {8'd2, 8'd2}) begin errors++; $display("FAIL abort_pre: got %h exp 0202", {bus.oVecCnt, bus.oErrCnt}); end
        bus.iA = 1'b1; bus.iB = 1'b1; bus.iValid = 1'b1;
        @(posedge clk); #1;
        bus.iValid = 1'b0;
        bus.iStart = 1'b1;
        @(posedge clk); #1;
        bus.iStart = 1'b0;
        checks++; if ({bus.oVecCnt, bus.oErrCnt} !== 16'h0000) begin errors++; $display("FAIL abort_cnts: got %h exp 0000", {bus.oVecCnt, bus.oErrCnt}); end
        checks++; if ({bus.oFirstAB, bus.oMismatch, bus.oCovered} !== 9'h000) begin errors++; $display("FAIL abort_regs: got %h exp 000", {bus.oFirstAB, bus.oMismatch, bus.oCovered}); end
        repeat (4) @(posedge clk); #1;
        checks++; if ({bus.oBusy, bus.oVecCnt} !== {1'b1, 8'd0}) begin errors++; $display("FAIL abort_armed: got %h exp 100", {bus.oBusy, bus.oVecCnt}); end
        or_stuck0 = 1'b0;
        apply_vec(2'b11);
        apply_vec(2'b00);
        apply_vec(2'b01);
        checks++; if (bus.oDone !== 1'b0) begin errors++; $display("FAIL abort_early_done: got %b exp 0", bus.oDone); end
        apply_vec(2'b10);
        checks++; if ({bus.oDone, bus.oPass, bus.oVecCnt, bus.oErrCnt} !== {1'b1, 1'b1, 8'd4, 8'd0}) begin errors++; $display("FAIL abort_rerun: got %h exp 30400", {bus.oDone, bus.oPass, bus.oVecCnt, bus.oErrCnt}); end
    endtask

    task automatic test_async_reset();
        or_stuck0 = 1'b1;
        pulse_start();
        apply_vec(2'b10);
        checks++; if ({bus.oErrCnt, bus.oFirstAB, bus.oMismatch} !== {8'd1, 2'b10, 3'b010}) begin errors++; $display("FAIL prereset_state: got %h exp %h", {bus.oErrCnt, bus.oFirstAB, bus.oMismatch}, {8'd1, 2'b10, 3'b010}); end
        bus.iA = 1'b1; bus.iB = 1'b1; bus.iValid = 1'b1;
        @(posedge clk); #1;
        bus.iValid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++; if ({bus.oBusy, bus.oDone, bus.oPass, bus.oOverrun} !== 4'b0000) begin errors++; $display("FAIL async_flags: got %b exp 0000", {bus.oBusy, bus.oDone, bus.oPass, bus.oOverrun}); end
        checks++; if ({bus.oVecCnt, bus.oErrCnt, bus.oFirstAB, bus.oMismatch} !== 21'h0) begin errors++; $display("FAIL async_regs: got %h exp 0", {bus.oVecCnt, bus.oErrCnt, bus.oFirstAB, bus.oMismatch}); end
        @(posedge clk); #1;
        rst = 1'b0;
        or_stuck0 = 1'b0;
        repeat (5) @(posedge clk); #1;
        checks++; if ({bus.oBusy, bus.oVecCnt} !== 9'h000) begin errors++; $display("FAIL async_idle: got %h exp 000", {bus.oBusy, bus.oVecCnt}); end
    endtask

    task automatic test_saturation();
        logic [1:0] ab;
        bus2.iStart = 1'b1;
        @(posedge clk); #1;
        bus2.iStart = 1'b0;
        for (int i = 0; i < 255; i++) begin
            ab = 2'(i + 1);
            bus2.iA = ab[1]; bus2.iB = ab[0]; bus2.iValid = 1'b1;
            @(posedge clk); #1;
            bus2.iValid = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end
        checks++; if (bus2.oErrCnt !== 8'hFF) begin errors++; $display("FAIL sat_errcnt: got %h exp ff", bus2.oErrCnt); end
        checks++; if ({bus2.oDone, bus2.oPass, bus2.oVecCnt} !== {1'b1, 1'b0, 8'hFF}) begin errors++; $display("FAIL sat_done: got %h exp 2ff", {bus2.oDone, bus2.oPass, bus2.oVecCnt}); end
        checks++; if ({bus2.oFirstAB, bus2.oMismatch} !== {2'b01, 3'b001}) begin errors++; $display("FAIL sat_first_mm: got %b exp 01001", {bus2.oFirstAB, bus2.oMismatch}); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef GATE_CHK_COVERAGE_EN
        exp_cov_full = 4'b1111;
`else
        exp_cov_full = 4'b0000;
`endif
        bus.iStart = 1'b0; bus.iValid = 1'b0; bus.iA = 1'b0; bus.iB = 1'b0;
        bus2.iStart = 1'b0; bus2.iValid = 1'b0; bus2.iA = 1'b0; bus2.iB = 1'b0;
        test_reset();
        test_pass_run();
        test_stuck_or();
        test_overrun();
        test_abort();
        test_async_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
